// File: rtl/sap_control_datapath.sv
// -----------------------------------------------------------------------------
// sap_control_datapath
//   Control and arithmetic core of the SAP-1 8-bit computer: a six-state
//   one-hot ring counter with its control-word decoder, the accumulator and
//   the adder/subtractor. The W bus itself is muxed at the top level; this
//   block only offers a value (bus_out) together with an output enable.
//
// Ports
//   clock         in   system clock, all state changes on the rising edge
//   reset         in   asynchronous active-low reset
//   instruction   in   opcode nibble from the instruction register
//   w_bus_in      in   current W bus value (accumulator load source)
//   b_in          in   B register value (ALU operand b)
//   control_word  out  {Cp,Ep,Lm_n,Ce_n,Li_n,Ei_n,La_n,Ea,Su,Eu,Lb_n,Lo_n}
//   bus_out       out  value this block drives onto the W bus
//   bus_oe        out  high while bus_out is valid (Ea or Eu)
//   acc_value     out  accumulator contents (ALU operand a)
//   carry         out  ALU carry-out on add, no-borrow on subtract
//   t_state       out  one-hot ring state, bit0 = T1 ... bit5 = T6
//   halted        out  high once HLT has executed, cleared only by reset
// -----------------------------------------------------------------------------
module sap_control_datapath #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [3:0]       instruction,
  input  logic [WIDTH-1:0] w_bus_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [11:0]      control_word,
  output logic [WIDTH-1:0] bus_out,
  output logic             bus_oe,
  output logic [WIDTH-1:0] acc_value,
  output logic             carry,
  output logic [5:0]       t_state,
  output logic             halted
);

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } ring_e;

  localparam logic [3:0]  OP_LDA = 4'b0000;
  localparam logic [3:0]  OP_ADD = 4'b0001;
  localparam logic [3:0]  OP_SUB = 4'b0010;
  localparam logic [3:0]  OP_OUT = 4'b1110;
  localparam logic [3:0]  OP_HLT = 4'b1111;
  localparam logic [11:0] CW_IDLE = 12'h3E3;

  ring_e            r_state;
  ring_e            w_next_state;
  logic             r_halted;
  logic [WIDTH-1:0] r_acc;
  logic [11:0]      w_cw;
  logic             w_set_halt;
  logic             w_la_n;
  logic             w_ea;
  logic             w_su;
  logic             w_eu;
  logic [WIDTH-1:0] w_b_operand;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_bus_out;
  logic             w_bus_oe;

  // Ring counter state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= T1;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Ring counter advance; frozen while halted, any corrupted code recovers to T1
  always_comb begin
    w_next_state = r_state;
    if (r_halted) begin
      w_next_state = r_state;
    end else begin
      case (r_state)
        T1:      w_next_state = T2;
        T2:      w_next_state = T3;
        T3:      w_next_state = T4;
        T4:      w_next_state = T5;
        T5:      w_next_state = T6;
        T6:      w_next_state = T1;
        default: w_next_state = T1;
      endcase
    end
  end

  // HLT takes effect on the edge that ends its T4
  assign w_set_halt = (r_state == T4) && (instruction == OP_HLT) && !r_halted;

  // Halt flag, sticky until reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_halted <= 1'b0;
    end else if (w_set_halt) begin
      r_halted <= 1'b1;
    end else begin
      r_halted <= r_halted;
    end
  end

  // Control-word decode: fetch in T1-T3, opcode-dependent execute in T4-T6
  always_comb begin
    w_cw = CW_IDLE;
    if (r_halted) begin
      w_cw = CW_IDLE;
    end else begin
      case (r_state)
        T1: w_cw = 12'h5E3;
        T2: w_cw = 12'hBE3;
        T3: w_cw = 12'h263;
        T4: begin
          case (instruction)
            OP_LDA, OP_ADD, OP_SUB: w_cw = 12'h1A3;
            OP_OUT:                 w_cw = 12'h3F2;
            default:                w_cw = CW_IDLE;
          endcase
        end
        T5: begin
          case (instruction)
            OP_LDA:         w_cw = 12'h2C3;
            OP_ADD, OP_SUB: w_cw = 12'h2E1;
            default:        w_cw = CW_IDLE;
          endcase
        end
        T6: begin
          case (instruction)
            OP_ADD:  w_cw = 12'h3C7;
            OP_SUB:  w_cw = 12'h3CF;
            default: w_cw = CW_IDLE;
          endcase
        end
        default: w_cw = CW_IDLE;
      endcase
    end
  end

  assign w_la_n = w_cw[5];
  assign w_ea   = w_cw[4];
  assign w_su   = w_cw[3];
  assign w_eu   = w_cw[2];

  // Accumulator: loads from the bus when La_n is low and the machine is running
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_acc <= {WIDTH{1'b0}};
    end else if (!w_la_n && !r_halted) begin
      r_acc <= w_bus_in;
    end else begin
      r_acc <= r_acc;
    end
  end

  // Subtraction as A + ~B + 1; the extra top bit is carry, i.e. no-borrow (A >= B)
  assign w_b_operand = w_su ? ~b_in : b_in;
  assign w_sum       = {1'b0, r_acc} + {1'b0, w_b_operand} + {{WIDTH{1'b0}}, w_su};

  // Bus drive priority: accumulator, then ALU, otherwise released
  always_comb begin
    w_bus_out = {WIDTH{1'b0}};
    w_bus_oe  = 1'b0;
    if (w_ea) begin
      w_bus_out = r_acc;
      w_bus_oe  = 1'b1;
    end else if (w_eu) begin
      w_bus_out = w_sum[WIDTH-1:0];
      w_bus_oe  = 1'b1;
    end else begin
      w_bus_out = {WIDTH{1'b0}};
      w_bus_oe  = 1'b0;
    end
  end

  assign control_word = w_cw;
  assign bus_out      = w_bus_out;
  assign bus_oe       = w_bus_oe;
  assign acc_value    = r_acc;
  assign carry        = w_sum[WIDTH];
  assign t_state      = r_state;
  assign halted       = r_halted;

endmodule

// File: tb/tb_sap_control_datapath.sv
// -----------------------------------------------------------------------------
// tb_sap_control_datapath
//   Scoreboard bench: the stimulus process drives one set of inputs per clock
//   and pushes the reference model's expected outputs; a monitor on the
//   falling edge pops and compares. The reference model tracks the machine as
//   (step number, accumulator, halted) and builds control words from a table
//   of named active signals.
// -----------------------------------------------------------------------------
module tb_sap_control_datapath;

  localparam int W = 8;

  // Control-word bit masks, {Cp,Ep,Lm_n,Ce_n,Li_n,Ei_n,La_n,Ea,Su,Eu,Lb_n,Lo_n}
  localparam logic [11:0] CP = 12'h800, EP = 12'h400, LM = 12'h200, CE = 12'h100;
  localparam logic [11:0] LI = 12'h080, EI = 12'h040, LA = 12'h020, EA = 12'h010;
  localparam logic [11:0] SU = 12'h008, EU = 12'h004, LB = 12'h002, LO = 12'h001;
  // All active-low bits high, all active-high bits low
  localparam logic [11:0] INACT = LM | CE | LI | EI | LA | LB | LO;

  logic         clock;
  logic         reset;
  logic [3:0]   instruction;
  logic [W-1:0] w_bus_in;
  logic [W-1:0] b_in;
  logic [11:0]  control_word;
  logic [W-1:0] bus_out;
  logic         bus_oe;
  logic [W-1:0] acc_value;
  logic         carry;
  logic [5:0]   t_state;
  logic         halted;

  sap_control_datapath #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .instruction(instruction),
    .w_bus_in(w_bus_in), .b_in(b_in), .control_word(control_word),
    .bus_out(bus_out), .bus_oe(bus_oe), .acc_value(acc_value),
    .carry(carry), .t_state(t_state), .halted(halted)
  );

  typedef struct {
    logic [11:0]  cw;
    logic [W-1:0] bus;
    logic         oe;
    logic [W-1:0] acc;
    logic         cy;
    logic [5:0]   ts;
    logic         hlt;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state
  int   m_step   = 0;   // 0 = T1 ... 5 = T6
  int   m_acc    = 0;
  bit   m_halted = 1'b0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Which signals are active for a given step/opcode
  function automatic logic [11:0] model_mask(input int step, input int op, input bit hlt);
    logic [11:0] m;
    m = 12'h000;
    if (!hlt) begin
      if (step == 0) m = EP | LM;
      else if (step == 1) m = CP;
      else if (step == 2) m = CE | LI;
      else if (step == 3) begin
        if (op <= 2) m = LM | EI;
        else if (op == 14) m = EA | LO;
      end else if (step == 4) begin
        if (op == 0) m = CE | LA;
        else if (op == 1 || op == 2) m = CE | LB;
      end else begin
        if (op == 1) m = LA | EU;
        else if (op == 2) m = LA | SU | EU;
      end
    end
    return m;
  endfunction

  // Clock edge as seen by the model, using the inputs present at that edge
  task automatic model_edge();
    logic [11:0] m;
    m = model_mask(m_step, int'(instruction), m_halted);
    if (reset && !m_halted) begin
      if ((m & LA) != 12'h000) m_acc = int'(w_bus_in);
      if (m_step == 3 && instruction == 4'hF) m_halted = 1'b1;
      m_step = (m_step + 1) % 6;
    end
  endtask

  task automatic push_expected();
    exp_t        e;
    logic [11:0] m;
    int          a, b, res;
    bit          cy;
    m = model_mask(m_step, int'(instruction), m_halted);
    a = m_acc;
    b = int'(b_in);
    if ((m & SU) != 12'h000) begin
      res = (a - b) & 255;
      cy  = (a >= b);
    end else begin
      res = (a + b) & 255;
      cy  = ((a + b) > 255);
    end
    e.cw  = INACT ^ m;
    e.cy  = cy;
    e.acc = W'(a);
    e.ts  = 6'(1 << m_step);
    e.hlt = m_halted;
    if ((m & EA) != 12'h000) begin
      e.bus = W'(a);
      e.oe  = 1'b1;
    end else if ((m & EU) != 12'h000) begin
      e.bus = W'(res);
      e.oe  = 1'b1;
    end else begin
      e.bus = '0;
      e.oe  = 1'b0;
    end
    q.push_back(e);
  endtask

  // One clock: model sees the edge, then new inputs are applied and expected pushed
  task automatic cycle(input logic rst, input logic [3:0] op, input logic [W-1:0] w, input logic [W-1:0] b);
    @(posedge clock);
    model_edge();
    #1;
    reset       = rst;
    instruction = op;
    w_bus_in    = w;
    b_in        = b;
    if (!rst) begin
      m_step   = 0;
      m_acc    = 0;
      m_halted = 1'b0;
    end
    push_expected();
  endtask

  // A full six-state instruction with given B and bus values in T5/T6
  task automatic run_instr(input logic [3:0] op, input logic [W-1:0] b,
                           input logic [W-1:0] w5, input logic [W-1:0] w6);
    for (int k = 0; k < 6; k++) begin
      if (k == 4) cycle(1'b1, op, w5, b);
      else if (k == 5) cycle(1'b1, op, w6, b);
      else cycle(1'b1, op, W'($urandom), b);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the oldest expectation
  always @(negedge clock) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("control_word", {4'h0, control_word}, {4'h0, e.cw});
      chk("t_state",      {10'h0, t_state},     {10'h0, e.ts});
      chk("halted",       {15'h0, halted},      {15'h0, e.hlt});
      chk("acc_value",    {8'h0, acc_value},    {8'h0, e.acc});
      chk("bus_oe",       {15'h0, bus_oe},      {15'h0, e.oe});
      chk("bus_out",      {8'h0, bus_out},      {8'h0, e.bus});
      chk("carry",        {15'h0, carry},       {15'h0, e.cy});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] acc_before;
    int           sel;
    logic [3:0]   op;
    reset       = 1'b0;
    instruction = 4'h0;
    w_bus_in    = '0;
    b_in        = '0;

    // Held in reset, then released
    cycle(1'b0, 4'h0, 8'h00, 8'h00);
    cycle(1'b0, 4'h0, 8'h00, 8'h00);
    chk("reset_word", {4'h0, control_word}, 16'h05E3);
    cycle(1'b1, 4'h0, 8'h00, 8'h00);
    cycle(1'b1, 4'h0, 8'h00, 8'h00);
    chk("release_T2_word", {4'h0, control_word}, 16'h0BE3);
    for (int k = 0; k < 4; k++) cycle(1'b1, 4'h0, 8'h00, 8'h00);

    // LDA then ADD, sum fed back onto the bus
    run_instr(4'h0, 8'h00, 8'h06, 8'h00);
    run_instr(4'h1, 8'h02, 8'h00, 8'h08);
    chk("add_word", {4'h0, control_word}, 16'h03C7);
    chk("add_bus",  {8'h0, bus_out}, 16'h0008);
    chk("add_carry", {15'h0, carry}, 16'h0000);
    run_instr(4'h0, 8'h00, 8'hFF, 8'h00);
    run_instr(4'h1, 8'h01, 8'h00, 8'h00);
    chk("add_wrap_bus", {8'h0, bus_out}, 16'h0000);
    chk("add_wrap_carry", {15'h0, carry}, 16'h0001);

    // SUB both ways round
    run_instr(4'h0, 8'h00, 8'h02, 8'h00);
    run_instr(4'h2, 8'h08, 8'h00, 8'hFA);
    chk("sub_word", {4'h0, control_word}, 16'h03CF);
    chk("sub_neg_bus", {8'h0, bus_out}, 16'h00FA);
    chk("sub_neg_carry", {15'h0, carry}, 16'h0000);
    run_instr(4'h0, 8'h00, 8'h08, 8'h00);
    run_instr(4'h2, 8'h02, 8'h00, 8'h06);
    chk("sub_pos_bus", {8'h0, bus_out}, 16'h0006);
    chk("sub_pos_carry", {15'h0, carry}, 16'h0001);

    // OUT
    run_instr(4'h0, 8'h00, 8'h0A, 8'h00);
    for (int k = 0; k < 4; k++) cycle(1'b1, 4'hE, 8'h55, 8'h33);
    chk("out_word", {4'h0, control_word}, 16'h03F2);
    chk("out_bus", {8'h0, bus_out}, 16'h000A);
    cycle(1'b1, 4'hE, 8'h55, 8'h33);
    cycle(1'b1, 4'hE, 8'h55, 8'h33);
    chk("out_T6_oe", {15'h0, bus_oe}, 16'h0000);

    // Reset asserted between edges during T4 of an LDA
    for (int k = 0; k < 4; k++) cycle(1'b1, 4'h0, 8'h77, 8'h00);
    cycle(1'b0, 4'h0, 8'h77, 8'h00);
    cycle(1'b1, 4'h0, 8'h00, 8'h00);
    for (int k = 0; k < 5; k++) cycle(1'b1, 4'h3, 8'h00, 8'h00);

    // Randomised instruction stream, opcode may change in any state
    for (int n = 0; n < 300; n++) begin
      sel = int'($urandom_range(0, 5));
      if (sel < 3) op = 4'(sel);
      else if (sel == 3) op = 4'hE;
      else op = 4'($urandom_range(3, 13));
      cycle(($urandom_range(0, 59) != 0) ? 1'b1 : 1'b0, op, W'($urandom), W'($urandom));
    end
    for (int k = 0; k < 6; k++) cycle(1'b0, 4'h0, 8'h00, 8'h00);
    cycle(1'b1, 4'h0, 8'h00, 8'h00);
    for (int k = 0; k < 5; k++) cycle(1'b1, 4'h0, 8'h00, 8'h00);

    // HLT: freezes at T5 with idle word for 20 cycles, reset restarts
    run_instr(4'h0, 8'h00, 8'h3C, 8'h00);
    acc_before = acc_value;
    for (int k = 0; k < 4; k++) cycle(1'b1, 4'hF, 8'h11, 8'h22);
    cycle(1'b1, 4'h0, 8'h99, 8'h22);
    chk("hlt_flag", {15'h0, halted}, 16'h0001);
    chk("hlt_tstate", {10'h0, t_state}, 16'h0010);
    for (int k = 0; k < 20; k++) cycle(1'b1, 4'($urandom), W'($urandom), W'($urandom));
    chk("hlt_acc_hold", {8'h0, acc_value}, {8'h0, acc_before});
    cycle(1'b0, 4'h0, 8'h00, 8'h00);
    cycle(1'b1, 4'h0, 8'h00, 8'h00);
    cycle(1'b1, 4'h0, 8'h00, 8'h00);
    chk("restart_T2_word", {4'h0, control_word}, 16'h0BE3);

    @(negedge clock);
    #1;
    chk("scoreboard_drained", 16'(q.size()), 16'h0000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sap_control_datapath.md
Name: sap_control_datapath

Overview:
- Control and arithmetic core of the SAP-1 8-bit educational computer: 6-state ring-counter controller emitting the 12-bit control word, plus the accumulator (A) and the adder/subtractor (ALU).
- The shared W bus is modelled as an input (`w_bus_in`) plus a driven value with output enable; the top level muxes the bus.
- The program counter, MAR, RAM, instruction register, B register and output register sit outside this block.

Parameters:
- WIDTH, 8, data width of accumulator, ALU and bus.

Ports:
- clock  in  1  single system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- instruction  in  4  opcode nibble from the instruction register.
- w_bus_in  in  WIDTH  current W bus value.
- b_in  in  WIDTH  B register value (ALU operand b).
- control_word  out  12  bits [11:0] = {Cp, Ep, Lm_n, Ce_n, Li_n, Ei_n, La_n, Ea, Su, Eu, Lb_n, Lo_n}.
- bus_out  out  WIDTH  value this block drives onto W bus.
- bus_oe  out  1  high when bus_out is valid (Ea or Eu).
- acc_value  out  WIDTH  accumulator contents (ALU operand a).
- carry  out  1  ALU carry-out (add) / no-borrow (subtract).
- t_state  out  6  one-hot ring state, bit0 = T1 … bit5 = T6.
- halted  out  1  high after HLT executed.

Behaviour:
- Reset (reset=0, asynchronous): t_state=6'b000001, accumulator=0, halted=0; control_word therefore 12'h5E3. Release is synchronised to the next rising edge.
- Ring counter: advances T1→T2→…→T6→T1 on each rising edge while halted=0; frozen while halted=1.
- control_word is combinational from t_state, instruction and halted.
- Inactive word is 12'h3E3 (Cp=Ep=Ea=Su=Eu=0, all active-low loads/enables high).
- Fetch, all opcodes:
  - T1 = 12'h5E3 (Ep, Lm_n).
  - T2 = 12'hBE3 (Cp).
  - T3 = 12'h263 (Ce_n, Li_n).
- Opcode 0000, LDA:
  - T4 = 12'h1A3 (Lm_n, Ei_n).
  - T5 = 12'h2C3 (Ce_n, La_n).
  - T6 = 12'h3E3.
- Opcode 0001, ADD:
  - T4 = 12'h1A3.
  - T5 = 12'h2E1 (Ce_n, Lb_n).
  - T6 = 12'h3C7 (La_n, Eu).
- Opcode 0010, SUB: same as ADD except T6 = 12'h3CF (La_n, Su, Eu).
- Opcode 1110, OUT:
  - T4 = 12'h3F2 (Ea, Lo_n).
  - T5, T6 = 12'h3E3.
- Opcode 1111, HLT:
  - T4 = 12'h3E3; halted sets at the rising edge ending T4 and stays set until reset.
  - While halted, control_word = 12'h3E3 regardless of t_state.
- Opcodes 0011–1101: NOP, 12'h3E3 in T4–T6.
- Accumulator: at a rising edge with La_n=0, A <= w_bus_in; otherwise A holds. It never loads while halted.
- ALU (combinational):
  - Su=0: result = A + B mod 2^WIDTH; carry = bit WIDTH of the full sum.
  - Su=1: result = A + ~B + 1 mod 2^WIDTH; carry = 1 when A >= B unsigned.
- Bus drive:
  - Ea=1: bus_out = A, bus_oe = 1.
  - else Eu=1: bus_out = ALU result, bus_oe = 1.
  - else: bus_out = 0, bus_oe = 0.
  - Ea and Eu are never asserted together by the decode.
- Instruction change mid-cycle (T1–T3): ignored until T4 decode. The opcode sampled combinationally during T4–T6 governs those states.
- Reset mid-instruction: immediate return to T1 with A=0; no partial load completes.

Test Plan:
- Reset: assert reset=0 mid-T4 of an LDA → t_state=000001, control_word=12'h5E3, acc_value=0, halted=0. Release → T2 word 12'hBE3 after one edge.
- Fetch + LDA: instruction=0000, w_bus_in=8'h06 during T5 → words 5E3, BE3, 263, 1A3, 2C3, 3E3 across T1–T6; acc_value=8'h06 after T5 edge.
- ADD: A=8'h06, b_in=8'h02, T6 → control_word=12'h3C7, bus_oe=1, bus_out=8'h08, carry=0. Feed bus back on w_bus_in → A=8'h08. Also A=8'hFF, B=8'h01 → bus_out=8'h00, carry=1.
- SUB: A=8'h02, b_in=8'h08 → T6 word 12'h3CF, bus_out=8'hFA, carry=0. A=8'h08, B=8'h02 → 8'h06, carry=1.
- OUT: A=8'h0A, instruction=1110, T4 → control_word=12'h3F2, bus_oe=1, bus_out=8'h0A. T5/T6 → 12'h3E3, bus_oe=0.
- HLT: instruction=1111 → after T4 edge halted=1, t_state frozen at T5, control_word=12'h3E3 for 20 cycles, A unchanged; reset=0 clears halted and restarts at T1.
